// File: rtl/rv32_pkg.sv
// Shared RV32I opcode constants, decoded-entry bundle and small helpers.
// Imported by the instruction queue and the immediate decoder.
package rv32_pkg;

  localparam int RV_XLEN = 32;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  typedef struct packed {
    logic [RV_XLEN-1:0] instr;
    logic [RV_XLEN-1:0] pc;
    logic [16:0]        opcode17;
    logic [4:0]         rd;
    logic [4:0]         rs1;
    logic [4:0]         rs2;
    logic [RV_XLEN-1:0] imm;
  } iq_entry_t;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/inst_queue_if.sv
// Fetch-side push and dispatch-side pop handshakes of the instruction queue.
// slave is the queue side, master is the producer/consumer side.
interface inst_queue_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic [XLEN-1:0] in_instr;
  logic [XLEN-1:0] in_pc;
  logic            in_ready;
  logic            out_ready;
  logic            out_valid;
  logic [XLEN-1:0] out_instr;
  logic [XLEN-1:0] out_pc;
  logic [16:0]     out_opcode;
  logic [4:0]      out_rd;
  logic [4:0]      out_rs1;
  logic [4:0]      out_rs2;
  logic [XLEN-1:0] out_imm;

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_instr, out_pc,
    output out_opcode, out_rd, out_rs1, out_rs2, out_imm
  );

  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_instr, out_pc,
    input  out_opcode, out_rd, out_rs1, out_rs2, out_imm
  );
endinterface

// File: rtl/rv32_imm_decode.sv
// Combinational RV32I field and immediate extraction.
// opcode17 is {funct7, funct3, opcode} taken verbatim from the instruction.
module rv32_imm_decode
  import rv32_pkg::*;
(
  input  logic [31:0] instr_i,
  output logic [16:0] opcode17_o,
  output logic [4:0]  rd_o,
  output logic [4:0]  rs1_o,
  output logic [4:0]  rs2_o,
  output logic [31:0] imm_o
);

  logic       s;
  logic [2:0] f3;

  assign s  = instr_i[31];
  assign f3 = instr_i[14:12];

  assign opcode17_o = {instr_i[31:25], f3, instr_i[6:0]};
  assign rd_o       = instr_i[11:7];
  assign rs1_o      = instr_i[19:15];
  assign rs2_o      = instr_i[24:20];

  always_comb begin
    imm_o = '0;
    unique case (instr_i[6:0])
      OP_LUI, OP_AUIPC:
        imm_o = {instr_i[31:12], 12'b0};
      OP_JAL:
        imm_o = {{11{s}}, s, instr_i[19:12],
                 instr_i[20], instr_i[30:21], 1'b0};
      OP_JALR, OP_LOAD:
        imm_o = {{20{s}}, instr_i[31:20]};
      OP_BRANCH:
        imm_o = {{19{s}}, s, instr_i[7],
                 instr_i[30:25], instr_i[11:8], 1'b0};
      OP_STORE:
        imm_o = {{20{s}}, instr_i[31:25], instr_i[11:7]};
      OP_IMM: begin
        // shift-immediates carry a 5-bit unsigned shamt
        if (f3 == 3'b001 || f3 == 3'b101)
          imm_o = {27'b0, instr_i[24:20]};
        else
          imm_o = {{20{s}}, instr_i[31:20]};
      end
      default:
        imm_o = '0;
    endcase
  end

endmodule

// File: rtl/inst_queue.sv
// Circular decoded-instruction queue between fetch and dispatch.
// Optional INST_QUEUE_STATS_EN adds saturating push/pop/stall/flush counters.
module inst_queue
  import rv32_pkg::*;
#(
  parameter  int DEPTH  = 16,
  parameter  int XLEN   = 32,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          rdy_in,
  input  logic          flush_in,
  inst_queue_if.slave   q,
  output logic [ADDR_W:0] count,
  output logic          full,
  output logic          empty
`ifdef INST_QUEUE_STATS_EN
  ,
  output logic [31:0]   stat_push,
  output logic [31:0]   stat_pop,
  output logic [31:0]   stat_full_stall,
  output logic [31:0]   stat_flush
`endif
);

  localparam int CW = ADDR_W + 1;

  logic [ADDR_W-1:0] head_q, head_d;
  logic [ADDR_W-1:0] tail_q, tail_d;
  logic [CW-1:0]     count_q, count_d;

  iq_entry_t mem_q [DEPTH];
  iq_entry_t wr_entry;
  iq_entry_t rd_entry;

  logic push, pop;

  assign count = count_q;
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

  // in_ready comes straight from the count register: no pop-to-push bypass
  assign q.in_ready  = !full;
  assign q.out_valid = !empty;

  assign push = q.in_valid && q.in_ready;
  assign pop  = q.out_valid && q.out_ready;

  rv32_imm_decode u_dec (
    .instr_i    (q.in_instr),
    .opcode17_o (wr_entry.opcode17),
    .rd_o       (wr_entry.rd),
    .rs1_o      (wr_entry.rs1),
    .rs2_o      (wr_entry.rs2),
    .imm_o      (wr_entry.imm)
  );

  assign wr_entry.instr = q.in_instr;
  assign wr_entry.pc    = q.in_pc;

  assign rd_entry     = mem_q[head_q];
  assign q.out_instr  = rd_entry.instr;
  assign q.out_pc     = rd_entry.pc;
  assign q.out_opcode = rd_entry.opcode17;
  assign q.out_rd     = rd_entry.rd;
  assign q.out_rs1    = rd_entry.rs1;
  assign q.out_rs2    = rd_entry.rs2;
  assign q.out_imm    = rd_entry.imm;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_in) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) tail_d = tail_q + ADDR_W'(1);
      if (pop)  head_d = head_q + ADDR_W'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (rdy_in) begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in && rdy_in && !flush_in && push)
      mem_q[tail_q] <= wr_entry;
  end

`ifdef INST_QUEUE_STATS_EN
  logic [31:0] st_push_q, st_pop_q, st_stall_q, st_flush_q;

  assign stat_push       = st_push_q;
  assign stat_pop        = st_pop_q;
  assign stat_full_stall = st_stall_q;
  assign stat_flush      = st_flush_q;

  // flush discards same-cycle handshakes, so they are not counted as fired
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      st_push_q  <= '0;
      st_pop_q   <= '0;
      st_stall_q <= '0;
      st_flush_q <= '0;
    end else if (rdy_in) begin
      if (push && !flush_in)  st_push_q  <= sat_inc(st_push_q);
      if (pop && !flush_in)   st_pop_q   <= sat_inc(st_pop_q);
      if (q.in_valid && full) st_stall_q <= sat_inc(st_stall_q);
      if (flush_in)           st_flush_q <= sat_inc(st_flush_q);
    end
  end
`endif

endmodule

// File: tb/tb_inst_queue.sv
// Scoreboard bench for inst_queue: directed pushes, decoupled pop monitor.
// Optional stat checks compile in with INST_QUEUE_STATS_EN.
module tb_inst_queue;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rdy = 1'b1;
  logic flush = 1'b0;
  logic [4:0] count;
  logic full, empty;
`ifdef INST_QUEUE_STATS_EN
  logic [31:0] st_push, st_pop, st_stall, st_flush;
`endif

  int total = 0;
  int passed = 0;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [4:0]  rd;
  } exp_t;

  exp_t sb[$];

  inst_queue_if #(.XLEN(32)) bus ();

  inst_queue #(.DEPTH(16), .XLEN(32)) dut (
    .clk_in   (clk),
    .rst_in   (rst),
    .rdy_in   (rdy),
    .flush_in (flush),
    .q        (bus),
    .count    (count),
    .full     (full),
    .empty    (empty)
`ifdef INST_QUEUE_STATS_EN
    ,
    .stat_push       (st_push),
    .stat_pop        (st_pop),
    .stat_full_stall (st_stall),
    .stat_flush      (st_flush)
`endif
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic logic [31:0] mk_addi(input int rd, input int imm);
    logic [11:0] i12;
    logic [4:0]  r5;
    i12 = 12'(imm);
    r5  = 5'(rd);
    return {i12, 5'd0, 3'b000, r5, 7'b0010011};
  endfunction

  // one clock: drive inputs, record what the DUT will accept, advance
  task automatic drive(input logic v, input logic [31:0] ins,
                       input logic [31:0] pc, input logic [31:0] imm,
                       input logic [4:0] rd, input logic ordy,
                       input logic fl);
    bus.in_valid  = v;
    bus.in_instr  = ins;
    bus.in_pc     = pc;
    bus.out_ready = ordy;
    flush         = fl;
    @(negedge clk);
    if (rst) sb.delete();
    else if (rdy) begin
      if (fl) sb.delete();
      else if (v && bus.in_ready) sb.push_back('{ins, pc, imm, rd});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic pop1();
    drive(1'b0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b1, 1'b0);
  endtask

  task automatic push_addi(input int rd, input int imm,
                           input logic [31:0] pc);
    drive(1'b1, mk_addi(rd, imm), pc, 32'(imm), 5'(rd), 1'b0, 1'b0);
  endtask

  // monitor: compare head against scoreboard whenever a pop will fire
  always @(negedge clk) begin
    exp_t e;
    if (!rst && rdy && !flush && bus.out_valid && bus.out_ready) begin
      total++;
      if (sb.size() == 0) begin
        $display("FAIL pop_unexpected: got pc %h expected no entry",
                 bus.out_pc);
      end else begin
        e = sb.pop_front();
        if (bus.out_pc === e.pc && bus.out_instr === e.instr &&
            bus.out_imm === e.imm && bus.out_rd === e.rd &&
            bus.out_opcode === {e.instr[31:25], e.instr[14:12],
                                e.instr[6:0]})
          passed++;
        else
          $display("FAIL pop pc %h: got instr %h imm %h rd %0d expected instr %h imm %h rd %0d",
                   e.pc, bus.out_instr, bus.out_imm, bus.out_rd,
                   e.instr, e.imm, e.rd);
      end
    end
  end

  logic [31:0] held_pc;

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_instr  = '0;
    bus.in_pc     = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    rst = 1'b0;
    idle();

    // single ADDI x1,x0,-1
    drive(1'b1, 32'hFFF00093, 32'h0, 32'hFFFFFFFF, 5'd1, 1'b0, 1'b0);
    chk("addi_valid", 32'(bus.out_valid), 32'd1);
    chk("addi_rd", 32'(bus.out_rd), 32'd1);
    chk("addi_imm", bus.out_imm, 32'hFFFFFFFF);
    chk("addi_op", 32'(bus.out_opcode[6:0]), 32'h13);
    chk("addi_count", 32'(count), 32'd1);
    pop1();
    chk("addi_drained", 32'(empty), 32'd1);

    // fill to 16
    for (int i = 0; i < 16; i++) push_addi(i, i + 1, 32'(4 * i));
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_in_ready", 32'(bus.in_ready), 32'd0);
    chk("fill_count", 32'(count), 32'd16);
    push_addi(7, 99, 32'h40);
    chk("full_ignored", 32'(count), 32'd16);
`ifdef INST_QUEUE_STATS_EN
    chk("stat_full_stall", st_stall, 32'd1);
`endif
    // pop while full: push still refused
    drive(1'b1, mk_addi(8, 100), 32'h44, 32'd100, 5'd8, 1'b1, 1'b0);
    chk("full_pop_count", 32'(count), 32'd15);
    for (int i = 0; i < 15; i++) pop1();
    chk("drain_empty", 32'(empty), 32'd1);

    // steady state with 3 in flight
    for (int i = 0; i < 3; i++) push_addi(i + 2, i, 32'h100 + 32'(4 * i));
    for (int k = 0; k < 40; k++) begin
      drive(1'b1, mk_addi(k % 32, k + 3), 32'h100 + 32'(4 * (k + 3)),
            32'(k + 3), 5'(k % 32), 1'b1, 1'b0);
      chk("steady_count", 32'(count), 32'd3);
    end
    for (int i = 0; i < 3; i++) pop1();
    chk("steady_empty", 32'(empty), 32'd1);

    // immediate formats
    drive(1'b1, 32'hFE000EE3, 32'h200, 32'hFFFFFFFC, 5'd29, 1'b0, 1'b0);
    drive(1'b1, 32'h0080006F, 32'h204, 32'h00000008, 5'd0,  1'b0, 1'b0);
    drive(1'b1, 32'h00112623, 32'h208, 32'h0000000C, 5'd12, 1'b0, 1'b0);
    drive(1'b1, 32'h00309093, 32'h20C, 32'h00000003, 5'd1,  1'b0, 1'b0);
    drive(1'b1, 32'h123450B7, 32'h210, 32'h12345000, 5'd1,  1'b0, 1'b0);
    chk("beq_imm_head", bus.out_imm, 32'hFFFFFFFC);
    for (int i = 0; i < 5; i++) pop1();

    // flush with simultaneous push and pop
    for (int i = 0; i < 5; i++) push_addi(i, i, 32'h300 + 32'(4 * i));
    chk("pre_flush_count", 32'(count), 32'd5);
    drive(1'b1, mk_addi(3, 77), 32'h3F0, 32'd77, 5'd3, 1'b1, 1'b1);
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_empty", 32'(empty), 32'd1);
`ifdef INST_QUEUE_STATS_EN
    chk("stat_flush", st_flush, 32'd1);
`endif
    push_addi(9, 5, 32'h500);
    chk("post_flush_pc", bus.out_pc, 32'h500);
    chk("post_flush_count", 32'(count), 32'd1);
    pop1();

    // rdy_in low freezes state
    for (int i = 0; i < 4; i++) push_addi(i, i, 32'h600 + 32'(4 * i));
    held_pc = bus.out_pc;
    rdy = 1'b0;
    drive(1'b1, mk_addi(1, 1), 32'h700, 32'd1, 5'd1, 1'b1, 1'b0);
    chk("frz1_count", 32'(count), 32'd4);
    drive(1'b0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b1);
    chk("frz2_count", 32'(count), 32'd4);
    drive(1'b1, mk_addi(2, 2), 32'h704, 32'd2, 5'd2, 1'b1, 1'b1);
    chk("frz3_count", 32'(count), 32'd4);
    chk("frz_head_pc", bus.out_pc, held_pc);
    chk("frz_head_exp", held_pc, 32'h600);
    rdy = 1'b1;

    // reset mid-fill
    push_addi(5, 5, 32'h610);
    rst = 1'b1;
    drive(1'b1, mk_addi(6, 6), 32'h614, 32'd6, 5'd6, 1'b1, 1'b0);
    rst = 1'b0;
    chk("midrst_count", 32'(count), 32'd0);
    chk("midrst_empty", 32'(empty), 32'd1);
    idle();
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/inst_queue.md
Name: inst_queue

Overview:
Parametrised circular instruction queue sitting between the icache fetch path and dispatch (ROB/RS).
- Each instruction is decoded on push into opcode/rd/rs1/rs2 and a fully sign-extended RV32I immediate; decoded fields are stored alongside instr and PC.
- The head entry is presented to dispatch through a valid/ready handshake.
- Supports single-cycle flush on branch mispredict, and simultaneous push and pop.

Parameters:
DEPTH, 16, number of entries; must be a power of 2, at least 2.
ADDR_W, $clog2(DEPTH), pointer width; derived, not overridden.
XLEN, 32, instruction/PC/immediate width.

Ports:
clk_in  input  1  clock
rst_in  input  1  synchronous active-high reset
rdy_in  input  1  global enable; low freezes all state
flush_in  input  1  mispredict flush from ROB
in_valid  input  1  icache delivers an instruction this cycle
in_instr  input  XLEN  raw instruction
in_pc  input  XLEN  instruction PC
in_ready  output  1  queue can accept a push (registered: !full)
out_ready  input  1  dispatch accepts head (ROB and RS not full)
out_valid  output  1  head entry valid (!empty)
out_instr  output  XLEN  head raw instruction
out_pc  output  XLEN  head PC
out_opcode  output  17  {funct7[16:10], funct3[9:7], opcode[6:0]}
out_rd  output  5  instr[11:7]
out_rs1  output  5  instr[19:15]
out_rs2  output  5  instr[24:20]
out_imm  output  XLEN  decoded immediate
count  output  ADDR_W+1  current occupancy
full  output  1  count==DEPTH
empty  output  1  count==0

Behaviour:
- Reset (rst_in=1 at posedge): head=tail=0, count=0, so empty=1, full=0, in_ready=1, out_valid=0.
  - Data outputs are don't-care while out_valid=0.
  - Reset overrides rdy_in and flush_in.
- rdy_in=0: no pointer, count or storage change; handshake inputs are ignored.
- Push fires when in_valid && in_ready; the entry is written at tail and tail wraps modulo DEPTH.
- Pop fires when out_valid && out_ready; head advances and wraps modulo DEPTH.
- Head outputs are combinational reads of storage[head].
  - A pushed entry is visible at the outputs the cycle after the push (1-cycle latency).
  - There is no same-cycle bypass.
- Simultaneous push and pop: both fire and count is unchanged.
- When full, in_ready=0 even if a pop occurs in that cycle (no pop-to-push bypass).
- count += push - pop; full and empty are derived from count.
- flush_in=1 (with rdy_in=1): head=tail=0 and count=0 next cycle.
  - A push or pop in the same cycle is discarded.
  - The following cycle accepts pushes normally.
- Decode on push, keyed on instr[6:0]:
  - LUI 0110111, AUIPC 0010111: imm={instr[31:12],12'b0}.
  - JAL 1101111: imm=sext({instr[31],instr[19:12],instr[20],instr[30:21],1'b0}).
  - JALR 1100111, LOAD 0000011: imm=sext(instr[31:20]).
  - BRANCH 1100011: imm=sext({instr[31],instr[7],instr[30:25],instr[11:8],1'b0}).
  - STORE 0100011: imm=sext({instr[31:25],instr[11:7]}).
  - OP-IMM 0010011: funct3 001/101 gives imm=zext(instr[24:20]); otherwise sext(instr[31:20]).
  - OP 0110011 and unknown opcodes: imm=0.
- out_opcode funct7 field is always instr[31:25], regardless of format; consumers mask as needed.

Optional Feature:
INST_QUEUE_STATS_EN.
- Defined: adds 32-bit outputs stat_push, stat_pop, stat_full_stall and stat_flush.
  - stat_push and stat_pop count fired pushes and pops.
  - stat_full_stall counts cycles with in_valid && full.
  - stat_flush counts flushes.
  - Counters increment only when rdy_in=1, clear on reset, saturate at all-ones, and are not cleared by flush.
- Undefined: ports and counters are absent; core behaviour is identical.

Decomposition:
- Shared package rv32_pkg:
  - Opcode localparams: OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE, OP_IMM, OP_REG.
  - A decoded-entry struct {instr, pc, opcode17, rd, rs1, rs2, imm}.
- One sub-module, rv32_imm_decode: purely combinational, instr in -> opcode17, rd, rs1, rs2, imm out; reused later by dispatch/RS.
- Queue storage and pointers stay in inst_queue.

Test Plan:
- Push ADDI x1,x0,-1 (0xFFF00093, pc 0x0) into empty queue, out_ready=0 -> next cycle out_valid=1, out_rd=1, out_imm=0xFFFFFFFF, out_opcode[6:0]=0010011, count=1.
- Push 16 instructions with out_ready=0 -> full=1, in_ready=0; 17th in_valid ignored, stat_full_stall=1; then pop all 16 in order with PCs 0x0..0x3C -> empty=1.
- Steady-state with count=3 and in_valid=out_ready=1 for 40 cycles -> count stays 3, pointers wrap, output order equals push order.
- Push BEQ 0xFE000EE3 -> imm=0xFFFFFFFC; push JAL 0x0080006F -> imm=0x8; push SW 0x00112623 -> imm=0xC; push SLLI 0x00309093 -> imm=3; push LUI 0x123450B7 -> imm=0x12345000.
- With count=5, assert flush_in together with in_valid and out_ready -> next cycle count=0, empty=1, no entry written; a push in the following cycle appears at head.
- With count=4, drop rdy_in for 3 cycles while toggling in_valid, out_ready and flush_in -> count and head outputs unchanged; rst_in mid-fill -> count=0 next cycle.
